// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register offsets, CTRL fields, mode codes and FSM states for timer_dev
package timer_pkg;

   localparam logic [1:0] OFF_CTRL     = 2'd0;
   localparam logic [1:0] OFF_PRESET   = 2'd1;
   localparam logic [1:0] OFF_COUNT    = 2'd2;
   localparam logic [1:0] OFF_PRESCALE = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - reloadable divider that ticks whenever it reaches zero
module timer_prescaler #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         run,
   input  logic [W-1:0] prescale,
   output logic         tick
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] div_d, div_q;

   assign tick = (div_q == '0);

   // Reload on LOAD and on every tick; otherwise count down while running.
   always_comb begin
      div_d = div_q;
      if (load) begin
         div_d = prescale;
      end else if (run) begin
         div_d = tick ? prescale : (div_q - ONE);
      end
   end

   // Divider register.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with level irq; TIMER_PRESCALE_EN adds PRESCALE at offset 3
module timer_dev
   import timer_pkg::*;
#(
   parameter logic [31:0] RESET_PRESET = 32'h0,
   parameter int          PRESCALE_W   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   input  logic        we,
   output logic [31:0] rd,
   output logic        irq
);

   logic [3:0]  ctrl_d, ctrl_q;
   logic [31:0] preset_d, preset_q;
   logic [31:0] count_d, count_q;
   logic        pending_d, pending_q;
   logic        irq_d, irq_q;
   state_e      state_d, state_q;

   logic        wr_ctrl, wr_preset;
   logic        set_pending;
   logic        step;
   logic [31:0] prescale_rd;
   logic        unused_addr;

   assign wr_ctrl     = we && (addr[3:2] == OFF_CTRL);
   assign wr_preset   = we && (addr[3:2] == OFF_PRESET);
   assign unused_addr = ^{addr[31:4], addr[1:0]};

`ifdef TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale_d, prescale_q;

   timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .load     (state_q == LOAD),
      .run      (state_q == CNT),
      .prescale (prescale_q),
      .tick     (step)
   );

   // PRESCALE register write and zero-extended read view.
   always_comb begin
      prescale_d  = prescale_q;
      if (we && (addr[3:2] == OFF_PRESCALE)) begin
         prescale_d = wd[PRESCALE_W-1:0];
      end
      prescale_rd = '0;
      prescale_rd[PRESCALE_W-1:0] = prescale_q;
   end

   // PRESCALE register.
   always_ff @(posedge clk) begin
      if (reset) begin
         prescale_q <= '0;
      end else begin
         prescale_q <= prescale_d;
      end
   end
`else
   logic [31:0] unused_prescale_w;

   assign step              = 1'b1;
   assign prescale_rd       = '0;
   assign unused_prescale_w = PRESCALE_W;
`endif

   // Next-state: FSM actions first, then CPU writes (CPU wins on CTRL), then pending set (set wins).
   always_comb begin
      ctrl_d      = ctrl_q;
      preset_d    = preset_q;
      count_d     = count_q;
      pending_d   = pending_q;
      state_d     = state_q;
      set_pending = 1'b0;

      case (state_q)
         IDLE: begin
            if (ctrl_q[CTRL_EN]) state_d = LOAD;
         end
         LOAD: begin
            count_d = preset_q;
            state_d = CNT;
         end
         CNT: begin
            if (!ctrl_q[CTRL_EN]) begin
               state_d = IDLE;
            end else if (step) begin
               if (count_q == 32'd0) begin
                  state_d     = INT;
                  set_pending = 1'b1;
               end else begin
                  count_d = count_q - 32'd1;
               end
            end
         end
         INT: begin
            case (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO])
               MODE_RELOAD: begin
                  state_d   = LOAD;
                  pending_d = 1'b0;
               end
               MODE_ONESHOT: begin
                  ctrl_d[CTRL_EN] = 1'b0;
                  state_d         = IDLE;
               end
               default: begin
                  ctrl_d[CTRL_EN] = 1'b0;
                  state_d         = IDLE;
               end
            endcase
         end
         default: state_d = IDLE;
      endcase

      if (wr_ctrl) begin
         ctrl_d    = wd[3:0];
         pending_d = 1'b0;
      end
      if (wr_preset) begin
         preset_d  = wd;
         pending_d = 1'b0;
      end
      if (set_pending) pending_d = 1'b1;

      irq_d = pending_d & ctrl_d[CTRL_IM];
   end

   // Register state.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q    <= 4'h0;
         preset_q  <= RESET_PRESET;
         count_q   <= 32'h0;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
         state_q   <= IDLE;
      end else begin
         ctrl_q    <= ctrl_d;
         preset_q  <= preset_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
         state_q   <= state_d;
      end
   end

   // Combinational read mux.
   always_comb begin
      rd = '0;
      case (addr[3:2])
         OFF_CTRL:     rd = {28'h0, ctrl_q};
         OFF_PRESET:   rd = preset_q;
         OFF_COUNT:    rd = count_q;
         OFF_PRESCALE: rd = prescale_rd;
         default:      rd = '0;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - randomized and directed checks of timer_dev against a behavioural model
module tb_timer_dev;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        we;
   logic [31:0] rd;
   logic        irq;

   int checks = 0;
   int errors = 0;

   timer_dev dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .wd    (wd),
      .we    (we),
      .rd    (rd),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_CNT  = 2;
   localparam int P_INT  = 3;

   int          m_phase;
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset, m_count, m_prescale, m_div;
   bit          m_pend, m_irq;

   task automatic model_edge(input logic rst, input logic wr, input logic [31:0] a, input logic [31:0] d);
      int          nphase;
      logic [3:0]  nctrl;
      logic [31:0] npreset, ncount, nprescale, ndiv;
      bit          npend, fire, stepping;
      if (rst) begin
         m_phase = P_IDLE; m_ctrl = 4'h0; m_preset = 32'h0; m_count = 32'h0;
         m_prescale = 32'h0; m_div = 32'h0; m_pend = 0; m_irq = 0;
         return;
      end
      nphase = m_phase; nctrl = m_ctrl; npreset = m_preset; ncount = m_count;
      nprescale = m_prescale; ndiv = m_div; npend = m_pend; fire = 0;
      stepping = (m_div == 0);
      case (m_phase)
         P_IDLE: if (m_ctrl[0]) nphase = P_LOAD;
         P_LOAD: begin ncount = m_preset; ndiv = m_prescale; nphase = P_CNT; end
         P_CNT: begin
            ndiv = stepping ? m_prescale : m_div - 1;
            if (!m_ctrl[0]) nphase = P_IDLE;
            else if (stepping) begin
               if (m_count == 0) begin nphase = P_INT; fire = 1; end
               else ncount = m_count - 1;
            end
         end
         default: begin
            if (m_ctrl[2:1] == 2'd1) begin nphase = P_LOAD; npend = 0; end
            else begin nctrl[0] = 1'b0; nphase = P_IDLE; end
         end
      endcase
      if (wr) begin
         case (a[3:2])
            2'd0: begin nctrl = d[3:0]; npend = 0; end
            2'd1: begin npreset = d; npend = 0; end
`ifdef TIMER_PRESCALE_EN
            2'd3: nprescale = {16'h0, d[15:0]};
`endif
            default: ;
         endcase
      end
      if (fire) npend = 1;
      m_phase = nphase; m_ctrl = nctrl; m_preset = npreset; m_count = ncount;
      m_prescale = nprescale; m_div = ndiv; m_pend = npend;
      m_irq = npend & nctrl[3];
   endtask

   function automatic logic [31:0] model_rd(input int off);
      case (off)
         0: return {28'h0, m_ctrl};
         1: return m_preset;
         2: return m_count;
`ifdef TIMER_PRESCALE_EN
         3: return m_prescale;
`endif
         default: return 32'h0;
      endcase
   endfunction

   logic [31:0] obs [4];
   logic        obs_irq;

   // One clock edge with the given inputs, then every offset and irq compared to the model.
   task automatic tick(input logic rst, input logic wr, input logic [31:0] a, input logic [31:0] d);
      reset = rst; we = wr; addr = a; wd = d;
      @(posedge clk);
      model_edge(rst, wr, a, d);
      #1;
      we = 1'b0; reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addr = i * 4;
         #1;
         obs[i] = rd;
         check($sformatf("rd%0d", i), rd, model_rd(i));
      end
      obs_irq = irq;
      check("irq", {31'h0, irq}, {31'h0, m_irq});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      tick(1'b0, 1'b1, a, d);
   endtask

   initial begin
      int first;
      int highs;
      int rises[$];
      logic prev;

      // Reset state.
      tick(1'b1, 1'b0, 32'h0, 32'h0);
      tick(1'b1, 1'b0, 32'h0, 32'h0);
      check("rst_ctrl", obs[0], 32'h0);
      check("rst_preset", obs[1], 32'h0);
      check("rst_count", obs[2], 32'h0);
      check("rst_off3", obs[3], 32'h0);
      check("rst_irq", {31'h0, obs_irq}, 32'h0);

      // One-shot, PRESET=5: irq at E+8, EN self-clears, CTRL=0x8 drops irq.
      wr(32'h4, 32'd5);
      wr(32'h0, 32'h9);
      first = -1;
      for (int k = 1; k <= 12; k++) begin
         idle(1);
         if (k == 3) check("os_count_k3", obs[2], 32'd4);
         if (obs_irq && first < 0) first = k;
      end
      check("os_latency", first, 32'd8);
      check("os_irq_hold", {31'h0, obs_irq}, 32'h1);
      check("os_ctrl", obs[0], 32'h8);
      wr(32'h0, 32'h8);
      check("os_irq_clear", {31'h0, obs_irq}, 32'h0);

      // Auto-reload, PRESET=2: one-cycle pulse every 5 cycles, EN stays set.
      wr(32'h4, 32'd2);
      wr(32'h0, 32'hB);
      prev = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         idle(1);
         if (obs_irq && !prev) rises.push_back(k);
         if (obs_irq && prev) check("ar_pulse_width", 32'd2, 32'd1);
         prev = obs_irq;
      end
      check("ar_pulses", rises.size(), 32'd6);
      foreach (rises[j]) check($sformatf("ar_rise%0d", j), rises[j], 5 * (j + 1));
      check("ar_en", obs[0], 32'hB);

      // IM=0: pending set but irq silent; CTRL=0x8 clears pending so irq stays low.
      wr(32'h0, 32'h0);
      wr(32'h4, 32'd10);
      wr(32'h0, 32'h1);
      highs = 0;
      for (int k = 0; k < 20; k++) begin
         idle(1);
         if (obs_irq) highs++;
      end
      check("im0_quiet", highs, 32'd0);
      wr(32'h0, 32'h8);
      idle(2);
      check("im0_cleared", {31'h0, obs_irq}, 32'h0);

      // COUNT write ignored, PRESET change deferred, freeze and reload.
      wr(32'h0, 32'h0);
      wr(32'h4, 32'd20);
      wr(32'h0, 32'h1);
      idle(5);
      wr(32'h8, 32'h1234);
      wr(32'h4, 32'd3);
      idle(2);
      wr(32'h0, 32'h0);
      idle(3);
      check("freeze_count", obs[2], 32'd12);
      check("new_preset", obs[1], 32'd3);
      wr(32'h0, 32'h9);
      idle(2);
      check("reload_count", obs[2], 32'd3);

      // PRESET=0 fires at E+3, then reset mid-operation drops irq.
      wr(32'h4, 32'd0);
      wr(32'h0, 32'h9);
      idle(3);
      check("p0_irq", {31'h0, obs_irq}, 32'h1);
      tick(1'b1, 1'b0, 32'h0, 32'h0);
      check("rst_mid_irq", {31'h0, obs_irq}, 32'h0);
      check("rst_mid_count", obs[2], 32'h0);
      check("rst_mid_ctrl", obs[0], 32'h0);

`ifdef TIMER_PRESCALE_EN
      // PRESCALE=1 halves the COUNT step rate.
      wr(32'hC, 32'd1);
      wr(32'h4, 32'd2);
      wr(32'h0, 32'h9);
      idle(4);
      check("ps_count_e4", obs[2], 32'd1);
      idle(2);
      check("ps_count_e6", obs[2], 32'd0);
      idle(2);
      check("ps_irq_e8", {31'h0, obs_irq}, 32'h1);
      tick(1'b1, 1'b0, 32'h0, 32'h0);
      check("ps_rst_prescale", obs[3], 32'h0);
      check("ps_rst_irq", {31'h0, obs_irq}, 32'h0);
`endif

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         logic        r, w;
         logic [31:0] a, d;
         r = ($urandom_range(0, 99) == 0);
         w = ($urandom_range(0, 3) == 0);
         a = $urandom_range(0, 15);
         d = $urandom();
         if (a[3:2] == 2'd1) d = d % 10;
         if (a[3:2] == 2'd3) d = d % 4;
         tick(r, w, a, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer that sits downstream of the system bridge.
- Two instances are used: DEV0 at 0x7F00 and DEV1 at 0x7F10.
- Consumes the bridge's device-local address, write data and per-device write enable. Returns read data and a level interrupt request (IRQ0/IRQ1) to the bridge, which feeds HWInt.
- Register window is 16 bytes: CTRL, PRESET, COUNT, plus PRESCALE when the optional feature is compiled in.

Parameters:
- RESET_PRESET, 32'h0, reset value of the PRESET register.
- PRESCALE_W, 16, width of the PRESCALE register and its counter. Used only when the optional feature is enabled.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  32  device-local byte address (0x0–0xF); only addr[3:2] is decoded.
- wd  input  32  write data.
- we  input  1  write enable, already qualified by the bridge's address hit.
- rd  output  32  read data, combinational from addr[3:2].
- irq  output  1  interrupt request, registered, level-sensitive.

Behaviour:
- Register map (by addr[3:2]):
  - 0 = CTRL[3:0]: bit0 EN, bits[2:1] MODE, bit3 IM. Upper bits read as 0; writes to them are ignored.
  - 1 = PRESET[31:0], read/write.
  - 2 = COUNT[31:0], read-only; writes are ignored.
  - 3 = reads 0, writes ignored (this is PRESCALE when TIMER_PRESCALE_EN is defined).
- Reset: CTRL=0, PRESET=RESET_PRESET, COUNT=0, pending=0, state=IDLE, irq=0. rd then reflects these values.
- irq = pending & IM, registered; it changes only on a clock edge.
- Writes are sampled on the rising edge when we=1.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE; COUNT holds its value.
    - Else if COUNT==0, go to INT and set pending<=1.
    - Else COUNT <= COUNT-1.
  - INT, MODE=0 (one-shot): EN <= 0; go to IDLE; pending stays set.
  - INT, MODE=1 (auto-reload): go to LOAD; pending <= 0, so irq is a one-cycle pulse.
  - MODE=2 and MODE=3 are reserved and behave as MODE=0.
- Latency: with EN written at edge E and PRESET=N, pending is set at edge E+N+3. Auto-reload period is N+3 cycles.
- PRESET=0: the interrupt fires at E+3.
- COUNT=0 with EN=1 in CNT always terminates; there is no wrap-around to 0xFFFFFFFF.
- A write to CTRL or PRESET clears pending. If the same edge also sets pending, set wins, so no interrupt is lost.
- A CPU write to CTRL on the same edge as the INT-state EN clear: the CPU write wins.
- A write to PRESET during CNT takes effect at the next LOAD only.
- Clearing EN mid-count freezes COUNT. Re-enabling passes through LOAD, so COUNT restarts from PRESET.
- Reset asserted mid-operation returns everything to reset values on that edge and drops irq the same edge.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - addr[3:2]=3 is PRESCALE[PRESCALE_W-1:0], read/write, reset 0. A PRESCALE_W-bit divider counter is added.
  - In CNT, COUNT decrements (or moves to INT) only on cycles where the divider is 0. The divider reloads from PRESCALE on those cycles and decrements otherwise.
  - The divider is loaded from PRESCALE in LOAD.
  - PRESCALE=0 is cycle-identical to the undefined build.
- Undefined: offset 3 reads 0, writes are ignored, and COUNT steps every cycle.

Decomposition:
- timer_pkg holds:
  - register offsets: CTRL=2'd0, PRESET=2'd1, COUNT=2'd2, PRESCALE=2'd3;
  - CTRL bit positions: EN, MODE, IM;
  - mode codes: MODE_ONESHOT=2'd0, MODE_RELOAD=2'd1;
  - the FSM state enum: IDLE, LOAD, CNT, INT.
- One sub-module, timer_prescaler (divider with reload and tick output), is instantiated only under TIMER_PRESCALE_EN.

Test Plan:
- Reset, then read all offsets -> rd = 0, 0, 0, 0 (PRESET reads RESET_PRESET); irq=0.
- PRESET=5, write CTRL=0x9 at edge E -> COUNT reads 5,4,3,2,1,0; irq rises after E+8 and stays high; CTRL reads 0x8. Writing CTRL=0x8 -> irq=0 the next cycle.
- PRESET=2, CTRL=0xB (auto-reload, IM=1) -> irq is a 1-cycle pulse every 5 cycles; EN stays 1.
- PRESET=10, CTRL=0x1 (IM=0) -> pending is set but irq stays 0. Writing CTRL=0x8 clears pending, so irq stays 0.
- Write COUNT=0x1234 -> ignored. During CNT write PRESET=3, then CTRL=0x0 -> COUNT freezes. CTRL=0x9 -> COUNT reloads to 3.
- TIMER_PRESCALE_EN, PRESCALE=1, PRESET=2, CTRL=0x9 -> COUNT steps every 2 cycles. Assert reset mid-count -> all registers 0 and irq=0 after that edge.
